// File: rtl/icache_refill_ctrl_pkg.sv
// Shared instruction-cache refill definitions: FSM state encoding and block geometry helpers.
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    // Number of memory beats needed to fill one cache block.
    function automatic int beatsPerBlock(input int blockBytes, input int beatBits);
        return (blockBytes * 8) / beatBits;
    endfunction

    function automatic int offsetBits(input int blockBytes);
        return $clog2(blockBytes);
    endfunction

    // A single-beat block still needs a one-bit counter to stay legal.
    function automatic int beatCntBits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch-side and memory-side signal bundle of the instruction-cache refill controller.
interface icache_refill_ctrl_if #(
    parameter int ADDR_BITS = 32,
    parameter int BEAT_BITS = 64
);
    logic                 CacheMiss;
    logic [ADDR_BITS-1:0] PCF;
    logic                 MemReq;
    logic [ADDR_BITS-1:0] MemAddr;
    logic                 MemAck;
    logic                 MemValid;
    logic [BEAT_BITS-1:0] MemRdData;
    logic                 RepEnable;
    logic [BEAT_BITS-1:0] RepWord;
    logic                 StallF;
    logic                 RefillBusy;

    // master: the refill controller; slave: fetch stage, set array and memory.
    modport master (
        input  CacheMiss, PCF, MemAck, MemValid, MemRdData,
        output MemReq, MemAddr, RepEnable, RepWord, StallF, RefillBusy
    );

    modport slave (
        output CacheMiss, PCF, MemAck, MemValid, MemRdData,
        input  MemReq, MemAddr, RepEnable, RepWord, StallF, RefillBusy
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: latches the missing block address, requests it
// from memory, and streams the returned beats to the set array one word per strobe.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int B         = 64,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    icache_refill_ctrl_if.master bus
);

    localparam int BEATS       = beatsPerBlock(B, BEAT_BITS);
    localparam int OFFSET_BITS = offsetBits(B);
    localparam int CNT_W       = beatCntBits(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_t        stateReg, stateNext;
    logic [CNT_W-1:0]     beatCntReg, beatCntNext;
    logic [ADDR_BITS-1:0] memAddrReg, memAddrNext;
    logic                 repEnableReg, repEnableNext;
    logic [BEAT_BITS-1:0] repWordReg, repWordNext;
    logic [ADDR_BITS-1:0] alignedAddr;

    // Block-aligned fetch address: offset bits forced to zero.
    for (genvar gi = 0; gi < ADDR_BITS; gi++) begin : g_align
        assign alignedAddr[gi] = bus.PCF[gi] & ((gi >= OFFSET_BITS) ? 1'b1 : 1'b0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg     <= IDLE;
            beatCntReg   <= '0;
            memAddrReg   <= '0;
            repEnableReg <= 1'b0;
            repWordReg   <= '0;
        end else begin
            stateReg     <= stateNext;
            beatCntReg   <= beatCntNext;
            memAddrReg   <= memAddrNext;
            repEnableReg <= repEnableNext;
            repWordReg   <= repWordNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        beatCntNext   = beatCntReg;
        memAddrNext   = memAddrReg;
        repEnableNext = 1'b0;
        repWordNext   = repWordReg;
        unique case (stateReg)
            IDLE: begin
                if (bus.CacheMiss) begin
                    memAddrNext = alignedAddr;
                    stateNext   = REQ;
                end
            end
            REQ: begin
                // A beat arriving alongside the ack is not part of the fill window.
                if (bus.MemAck) begin
                    beatCntNext = '0;
                    stateNext   = FILL;
                end
            end
            FILL: begin
                if (bus.MemValid) begin
                    repWordNext   = bus.MemRdData;
                    repEnableNext = 1'b1;
                    beatCntNext   = beatCntReg + CNT_W'(1);
                    if (beatCntReg == LAST_BEAT) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.MemReq     = (stateReg == REQ);
    assign bus.MemAddr    = memAddrReg;
    assign bus.RepEnable  = repEnableReg;
    assign bus.RepWord    = repWordReg;
    assign bus.RefillBusy = (stateReg != IDLE);
    assign bus.StallF     = bus.CacheMiss | (stateReg != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a stimulus thread queues expected replacement
// words, and a negedge monitor pops and compares them whenever RepEnable is seen.
module tb_icache_refill_ctrl;

    localparam int ADDR_BITS = 32;
    localparam int BEAT_BITS = 64;
    localparam int NBEATS    = 8;

    logic clk;
    logic reset;

    icache_refill_ctrl_if #(.ADDR_BITS(ADDR_BITS), .BEAT_BITS(BEAT_BITS)) bus ();

    icache_refill_ctrl #(.B(64), .BEAT_BITS(BEAT_BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulseCount = 0;
    logic [BEAT_BITS-1:0] expQ[$];

    // Monitor: every RepEnable strobe must match the next queued beat.
    always @(negedge clk) begin
        if (bus.RepEnable === 1'b1) begin
            pulseCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL rep_unexpected: RepEnable=1 RepWord=%h, required no strobe", bus.RepWord);
            end else begin
                logic [BEAT_BITS-1:0] w;
                w = expQ.pop_front();
                if (bus.RepWord !== w) begin
                    errors++;
                    $display("FAIL rep_word: got %h, required %h", bus.RepWord, w);
                end else begin
                    $display("rep beat ok: %h", w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full refill. Entry: controller in IDLE at posedge+1.
    task automatic runRefill(input logic [31:0] pc, input int ackDelay,
                             input logic [7:0] validPat, input int patLen,
                             input logic [63:0] seed, input bit holdMiss,
                             input bit validInReq, input bit ackWithValid,
                             input bit wiggle, input bit chain, input logic [31:0] nextPc);
        logic [31:0] expAddr;
        int beat;
        int p0;
        expAddr = pc & 32'hFFFF_FFC0;
        p0 = pulseCount;
        bus.CacheMiss = 1'b1;
        bus.PCF = pc;
        #1;
        chk("stall_on_miss", 64'(bus.StallF), 64'd1);
        tick();
        chk("req_memreq", 64'(bus.MemReq), 64'd1);
        chk("req_addr", 64'(bus.MemAddr), 64'(expAddr));
        bus.CacheMiss = holdMiss;
        for (int i = 0; i < ackDelay; i++) begin
            bus.MemValid = validInReq;
            bus.MemRdData = 64'hBAD0_0000_0000_0000 | 64'(i);
            tick();
            chk("req_hold", 64'(bus.MemReq), 64'd1);
            chk("req_addr_stable", 64'(bus.MemAddr), 64'(expAddr));
        end
        bus.MemAck = 1'b1;
        bus.MemValid = ackWithValid;
        bus.MemRdData = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.MemAck = 1'b0;
        bus.MemValid = 1'b0;
        chk("memreq_drop", 64'(bus.MemReq), 64'd0);
        chk("fill_busy", 64'(bus.RefillBusy), 64'd1);
        beat = 0;
        for (int i = 0; i < 64 && beat < NBEATS; i++) begin
            if (validPat[i % patLen]) begin
                bus.MemValid = 1'b1;
                bus.MemRdData = seed + 64'(beat) * 64'h0101_0101_0101_0101;
                expQ.push_back(bus.MemRdData);
                beat++;
            end else begin
                bus.MemValid = 1'b0;
                bus.MemRdData = 64'hFFFF_0000_FFFF_0000;
            end
            if (wiggle && i == 2) begin
                bus.CacheMiss = 1'b0;
                bus.PCF = 32'h0000_2000;
            end
            tick();
            chk("fill_stall", 64'(bus.StallF), 64'd1);
            chk("fill_busy", 64'(bus.RefillBusy), 64'd1);
            chk("fill_addr", 64'(bus.MemAddr), 64'(expAddr));
        end
        bus.MemValid = 1'b0;
        chk("done_memreq", 64'(bus.MemReq), 64'd0);
        chk("done_rep", 64'(bus.RepEnable), 64'd1);
        bus.CacheMiss = chain;
        bus.PCF = nextPc;
        tick();
        chk("idle_busy", 64'(bus.RefillBusy), 64'd0);
        chk("idle_stall", 64'(bus.StallF), 64'(chain));
        chk("pulses", 64'(pulseCount - p0), 64'(NBEATS));
        $display("refill pc=%h addr=%h pulses=%0d", pc, expAddr, pulseCount - p0);
    endtask

    initial begin
        reset = 1'b1;
        bus.CacheMiss = 1'b1;
        bus.PCF = 32'h0000_1234;
        bus.MemAck = 1'b0;
        bus.MemValid = 1'b0;
        bus.MemRdData = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_memreq", 64'(bus.MemReq), 64'd0);
        chk("rst_addr", 64'(bus.MemAddr), 64'd0);
        chk("rst_rep", 64'(bus.RepEnable), 64'd0);
        chk("rst_word", 64'(bus.RepWord), 64'd0);
        chk("rst_busy", 64'(bus.RefillBusy), 64'd0);
        chk("rst_stall_miss", 64'(bus.StallF), 64'd1);
        bus.CacheMiss = 1'b0;
        #1;
        chk("rst_stall_nomiss", 64'(bus.StallF), 64'd0);
        tick();
        reset = 1'b0;

        // Stray beats in IDLE must be ignored.
        bus.MemValid = 1'b1;
        bus.MemRdData = 64'h1111_2222_3333_4444;
        tick();
        tick();
        chk("idle_valid_busy", 64'(bus.RefillBusy), 64'd0);
        chk("idle_valid_stall", 64'(bus.StallF), 64'd0);
        bus.MemValid = 1'b0;
        tick();

        // Basic refill, ack after 3 cycles, consecutive beats.
        runRefill(32'h0000_1234, 3, 8'b1, 1, 64'hA000_0000_0000_0010,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Gapped beats 1,0,0; stray beats during REQ and with the ack.
        runRefill(32'h0000_33A8, 2, 8'b001, 3, 64'hB000_0000_0000_0020,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        // Miss/PCF disturbed mid-fill, then an immediate second miss.
        runRefill(32'h0000_1000, 1, 8'b1, 1, 64'hC000_0000_0000_0030,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5678);
        runRefill(32'h0000_5678, 0, 8'b011, 3, 64'hD000_0000_0000_0040,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset after the 4th beat of a refill.
        begin
            int p0;
            p0 = pulseCount;
            bus.CacheMiss = 1'b1;
            bus.PCF = 32'h0000_7010;
            tick();
            bus.MemAck = 1'b1;
            tick();
            bus.MemAck = 1'b0;
            for (int b = 0; b < 4; b++) begin
                bus.MemValid = 1'b1;
                bus.MemRdData = 64'hE000_0000_0000_0000 + 64'(b);
                expQ.push_back(bus.MemRdData);
                tick();
            end
            @(negedge clk);
            #1;
            reset = 1'b1;
            #1;
            chk("midrst_memreq", 64'(bus.MemReq), 64'd0);
            chk("midrst_addr", 64'(bus.MemAddr), 64'd0);
            chk("midrst_rep", 64'(bus.RepEnable), 64'd0);
            chk("midrst_word", 64'(bus.RepWord), 64'd0);
            chk("midrst_busy", 64'(bus.RefillBusy), 64'd0);
            chk("midrst_stall", 64'(bus.StallF), 64'd1);
            chk("midrst_pulses", 64'(pulseCount - p0), 64'd4);
            tick();
            reset = 1'b0;
            bus.CacheMiss = 1'b0;
            tick();
            tick();
            chk("postrst_busy", 64'(bus.RefillBusy), 64'd0);
            chk("postrst_pulses", 64'(pulseCount - p0), 64'd4);
            bus.MemValid = 1'b0;
        end
        runRefill(32'h0000_0040, 1, 8'b1, 1, 64'hF000_0000_0000_0050,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        tick();
        tick();
        chk("queue_empty", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter B, default 64, cache block size in bytes.
REQ-002 Parameter BEAT_BITS, default 64, memory beat / replacement word width.
REQ-003 Parameter ADDR_BITS, default 32, address width.
REQ-004 Derived constant BEATS = B*8/BEAT_BITS (8 at defaults); OFFSET_BITS = $clog2(B).
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 CacheMiss  input  1  miss indication from the cache set array for current fetch.
REQ-008 PCF  input  ADDR_BITS  current fetch address.
REQ-009 MemReq  output  1  refill request to memory, held until accepted.
REQ-010 MemAddr  output  ADDR_BITS  block-aligned refill address.
REQ-011 MemAck  input  1  memory accepts request this cycle.
REQ-012 MemValid  input  1  MemRdData carries a valid beat this cycle.
REQ-013 MemRdData  input  BEAT_BITS  refill beat data, lowest address beat first.
REQ-014 RepEnable  output  1  replacement word strobe to the cache set.
REQ-015 RepWord  output  BEAT_BITS  replacement word to the cache set.
REQ-016 StallF  output  1  fetch stall request.
REQ-017 RefillBusy  output  1  controller state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, FILL, DONE.
REQ-019 IDLE: CacheMiss=1 -> latch MemAddr = {PCF[ADDR_BITS-1:OFFSET_BITS], zeros}, go REQ.
REQ-020 REQ: MemReq=1, MemAddr stable; MemAck=1 -> FILL, beat counter cleared to 0.
REQ-021 FILL: each MemValid=1 cycle registers MemRdData into RepWord and pulses RepEnable high the following cycle; counter increments.
REQ-022 RepEnable SHALL be high exactly BEATS cycles per refill, one per beat, gaps allowed between beats.
REQ-023 Beat counter width $clog2(BEATS); the beat with counter = BEATS-1 SHALL move FSM to DONE (no wrap used).
REQ-024 DONE lasts exactly one cycle, then IDLE; final RepEnable pulse coincides with DONE.
REQ-025 StallF = CacheMiss OR (state != IDLE); combinational.
REQ-026 MemReq SHALL be high only in REQ; deasserts the cycle after MemAck sampled.
REQ-027 MemValid outside FILL SHALL be ignored (no RepEnable, no state change).
REQ-028 CacheMiss changes or PCF changes during REQ/FILL/DONE SHALL be ignored; refill is never aborted except by reset.
REQ-029 MemAck and first MemValid in same cycle: MemValid ignored (beats only counted in FILL).
REQ-030 Back-to-back misses: new miss sampled in IDLE no earlier than the cycle after DONE.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, counter 0, MemReq 0, MemAddr 0, RepEnable 0, RepWord 0, RefillBusy 0.
REQ-032 Reset mid-refill SHALL discard partial refill; no further RepEnable pulses until a new miss completes REQ.
REQ-033 StallF during reset equals CacheMiss.

Structure
REQ-034 State enum and BEATS/OFFSET_BITS derivation SHALL live in the shared cache package.
REQ-035 Single flat module; no sub-module required.

Verification
REQ-036 Miss at PCF=0x0000_1234, MemAck after 3 cycles, 8 consecutive beats -> MemAddr=0x0000_1200, 8 RepEnable pulses with RepWord = beats in order, IDLE two cycles after last beat.
REQ-037 Beats with MemValid gaps (pattern 1,0,0,1,...) -> exactly 8 RepEnable pulses, StallF high throughout, data order preserved.
REQ-038 MemValid pulses during IDLE and REQ -> no RepEnable, state unchanged.
REQ-039 reset asserted after 4th beat -> all outputs 0 same cycle; new miss at 0x0000_0040 refills fully with MemAddr=0x0000_0040.
REQ-040 CacheMiss deasserted mid-FILL and PCF changed to 0x0000_2000 -> refill of original block completes, MemAddr unchanged.
REQ-041 Second miss immediately after DONE -> new REQ starts the cycle after return to IDLE, StallF never drops.
